// File: rtl/minmax_sequencer.sv
// Streaming min/max tracker for 4-bit unsigned samples, time-sharing one comparator.
// Define MINMAX_IDX_EN to add min_idx/max_idx outputs holding the capture index.

module comparator (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic       lt,
    output logic       eq,
    output logic       gt
);

    assign lt = (x < y);
    assign eq = (x == y);
    assign gt = (x > y);

endmodule

module minmax_sequencer #(
    parameter int N_SAMPLES = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [3:0]       min_out,
    output logic [3:0]       max_out
`ifdef MINMAX_IDX_EN
   ,output logic [CNT_W-1:0] min_idx,
    output logic [CNT_W-1:0] max_idx
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IN,
        CMP_MIN,
        CMP_MAX,
        DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [3:0]       r_sample;
    logic [3:0]       r_min;
    logic [3:0]       r_max;
    logic             r_inReady;
    logic             r_busy;
    logic             r_done;
`ifdef MINMAX_IDX_EN
    logic [CNT_W-1:0] r_minIdx;
    logic [CNT_W-1:0] r_maxIdx;
`endif

    logic [3:0]       w_cmpY;
    logic             w_lt;
    logic             w_eq;
    logic             w_gt;
    logic [CNT_W-1:0] w_countNext;

    // One comparator serves both compare phases; the Y operand follows the phase.
    assign w_cmpY      = (r_state == CMP_MIN) ? r_min : r_max;
    assign w_countNext = r_count + CNT_W'(1);

    comparator u_cmp (
        .x  (r_sample),
        .y  (w_cmpY),
        .lt (w_lt),
        .eq (w_eq),
        .gt (w_gt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_sample  <= 4'h0;
            r_min     <= 4'h0;
            r_max     <= 4'h0;
            r_inReady <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef MINMAX_IDX_EN
            r_minIdx  <= '0;
            r_maxIdx  <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !abort) begin
                        r_count   <= '0;
                        r_state   <= WAIT_IN;
                        r_inReady <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end

                WAIT_IN: begin
                    if (abort) begin
                        r_count   <= '0;
                        r_state   <= IDLE;
                        r_inReady <= 1'b0;
                        r_busy    <= 1'b0;
                    end else if (in_valid) begin
                        // The first sample seeds both extremes without a compare.
                        if (r_count == '0) begin
                            r_min   <= in_data;
                            r_max   <= in_data;
                            r_count <= CNT_W'(1);
`ifdef MINMAX_IDX_EN
                            r_minIdx <= '0;
                            r_maxIdx <= '0;
`endif
                        end else begin
                            r_sample  <= in_data;
                            r_state   <= CMP_MIN;
                            r_inReady <= 1'b0;
                        end
                    end
                end

                CMP_MIN: begin
                    if (abort) begin
                        r_count <= '0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        if (w_lt && !w_eq) begin
                            r_min <= r_sample;
`ifdef MINMAX_IDX_EN
                            r_minIdx <= r_count;
`endif
                        end
                        r_state <= CMP_MAX;
                    end
                end

                CMP_MAX: begin
                    if (abort) begin
                        r_count <= '0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        // r_count still equals the 0-based index of the sample under test.
                        if (w_gt && !w_eq) begin
                            r_max <= r_sample;
`ifdef MINMAX_IDX_EN
                            r_maxIdx <= r_count;
`endif
                        end
                        r_count <= w_countNext;
                        if (w_countNext == CNT_W'(N_SAMPLES)) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= WAIT_IN;
                            r_inReady <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state   <= IDLE;
                    r_inReady <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = r_inReady;
    assign busy     = r_busy;
    assign done     = r_done;
    assign min_out  = r_min;
    assign max_out  = r_max;
`ifdef MINMAX_IDX_EN
    assign min_idx  = r_minIdx;
    assign max_idx  = r_maxIdx;
`endif

endmodule

// File: tb/tb_minmax_sequencer.sv
// Self-checking bench for minmax_sequencer with N_SAMPLES=4: directed and random runs
// compared against a queue-based min/max reference model.

module tb_minmax_sequencer;

    localparam int N  = 4;
    localparam int CW = 4;

    typedef logic [3:0] sample_q_t[$];

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic          in_valid;
    logic [3:0]    in_data;
    logic          in_ready;
    logic          busy;
    logic          done;
    logic [3:0]    min_out;
    logic [3:0]    max_out;
`ifdef MINMAX_IDX_EN
    logic [CW-1:0] min_idx;
    logic [CW-1:0] max_idx;
`endif

    int nChecks   = 0;
    int nFails    = 0;
    int edgeCnt   = 0;
    int doneCount = 0;
    int doneEdge  = -1;

    minmax_sequencer #(.N_SAMPLES(N), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .min_out  (min_out),
        .max_out  (max_out)
`ifdef MINMAX_IDX_EN
       ,.min_idx  (min_idx),
        .max_idx  (max_idx)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog so a stuck run still ends the simulation.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edgeCnt++;
        if (done === 1'b1) begin
            doneCount++;
            doneEdge = edgeCnt;
        end
    endtask

    // Reference model: strict less/greater keeps the earliest occurrence on ties.
    task automatic modelRun(input sample_q_t s, output int mn, output int mx,
                            output int mni, output int mxi);
        mn = s[0]; mx = s[0]; mni = 0; mxi = 0;
        for (int i = 1; i < s.size(); i++) begin
            if (int'(s[i]) < mn) begin mn = s[i]; mni = i; end
            if (int'(s[i]) > mx) begin mx = s[i]; mxi = i; end
        end
    endtask

    task automatic checkResults(input string tag, input sample_q_t s);
        int mn, mx, mni, mxi;
        modelRun(s, mn, mx, mni, mxi);
        checkOutput({tag, "_min"}, 32'(min_out), mn);
        checkOutput({tag, "_max"}, 32'(max_out), mx);
`ifdef MINMAX_IDX_EN
        checkOutput({tag, "_minIdx"}, 32'(min_idx), mni);
        checkOutput({tag, "_maxIdx"}, 32'(max_idx), mxi);
`endif
    endtask

    // Runs one sequence: start, feed samples (optionally with gaps), and wait for done.
    task automatic applyStimulus(input string tag, input sample_q_t s, input bit gaps,
                                 input bit waitDone);
        int idx;
        int budget;
        int guard;
        bit xfer;
        start     = 1'b1;
        edgeCnt   = -1;
        doneCount = 0;
        doneEdge  = -1;
        tick();
        start    = 1'b0;
        in_data  = s[0];
        in_valid = 1'b1;
        if (gaps) begin
            in_valid = 1'b0;
            tick();
            checkOutput({tag, "_readyIdle"}, 32'(in_ready), 1);
            in_valid = 1'b1;
        end
        idx    = 0;
        budget = 0;
        while (idx < s.size() && budget < 200) begin
            xfer = in_valid && in_ready;
            tick();
            budget++;
            if (xfer) begin
                idx++;
                if (idx < s.size()) in_data = s[idx];
                if (idx == 1) begin
                    checkOutput({tag, "_readyAfterFirst"}, 32'(in_ready), 1);
                end else begin
                    if (gaps) begin
                        in_valid = 1'b0;
                        in_data  = 4'($urandom_range(0, 15));
                    end
                    checkOutput({tag, "_readyCmp1"}, 32'(in_ready), 0);
                    tick();
                    checkOutput({tag, "_readyCmp2"}, 32'(in_ready), 0);
                    tick();
                    if (idx < s.size()) in_data = s[idx];
                    if (idx != N) checkOutput({tag, "_readyBack"}, 32'(in_ready), 1);
                    if (gaps) in_valid = 1'b1;
                end
            end
        end
        checkOutput({tag, "_xferCount"}, idx, s.size());
        if (waitDone) begin
            in_valid = 1'b0;
            guard = 0;
            while (doneCount == 0 && guard < 10) begin
                tick();
                guard++;
            end
            checkOutput({tag, "_doneSeen"}, doneCount, 1);
            tick();
            checkOutput({tag, "_doneSingle"}, doneCount, 1);
            checkOutput({tag, "_busyAfter"}, 32'(busy), 0);
            checkOutput({tag, "_readyAfter"}, 32'(in_ready), 0);
            if (!gaps) checkOutput({tag, "_doneEdge"}, doneEdge, 3 * N - 2);
        end
    endtask

    initial begin
        sample_q_t q;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'h0;
        #12;
        checkOutput("reset_min", 32'(min_out), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_ready", 32'(in_ready), 0);
        rst = 1'b0;
        tick();

        // Asynchronous reset in the middle of CMP_MAX.
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'd5;
        tick();
        in_data = 4'd3;
        tick();
        tick();
        checkOutput("midrun_min", 32'(min_out), 3);
        checkOutput("midrun_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        checkOutput("asyncRst_min", 32'(min_out), 0);
        checkOutput("asyncRst_max", 32'(max_out), 0);
        checkOutput("asyncRst_busy", 32'(busy), 0);
        checkOutput("asyncRst_ready", 32'(in_ready), 0);
        checkOutput("asyncRst_done", 32'(done), 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        checkOutput("afterRst_busy", 32'(busy), 0);

        $display("[TB] directed runs");
        q = '{4'd5, 4'd2, 4'd9, 4'd2};
        applyStimulus("basic", q, 1'b0, 1'b1);
        checkResults("basic", q);

        q = '{4'd7, 4'd7, 4'd7, 4'd7};
        applyStimulus("equal", q, 1'b0, 1'b1);
        checkResults("equal", q);

        q = '{4'd0, 4'd15, 4'd0, 4'd15};
        applyStimulus("bounds", q, 1'b0, 1'b1);
        checkResults("bounds", q);

        q = '{4'd5, 4'd2, 4'd9, 4'd2};
        applyStimulus("gaps", q, 1'b1, 1'b1);
        checkResults("gaps", q);

        // start and abort together in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        tick();
        checkOutput("startAbort_busy", 32'(busy), 0);
        start = 1'b0;
        abort = 1'b0;

        // Abort after two of four samples.
        q = '{4'd8, 4'd3};
        applyStimulus("abort", q, 1'b0, 1'b0);
        abort    = 1'b1;
        in_valid = 1'b0;
        tick();
        abort = 1'b0;
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_ready", 32'(in_ready), 0);
        tick();
        tick();
        checkOutput("abort_noDone", doneCount, 0);
        checkResults("abort", q);

        q = '{4'd12, 4'd4, 4'd6, 4'd13};
        applyStimulus("afterAbort", q, 1'b0, 1'b1);
        checkResults("afterAbort", q);

        $display("[TB] random runs");
        for (int r = 0; r < 8; r++) begin
            bit g;
            q = {};
            for (int i = 0; i < N; i++) q.push_back(4'($urandom_range(0, 15)));
            g = 1'($urandom_range(0, 1));
            applyStimulus($sformatf("rand%0d", r), q, g, 1'b1);
            checkResults($sformatf("rand%0d", r), q);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/minmax_sequencer.md
Name: minmax_sequencer

Overview:
- Streaming min/max tracker for 4-bit unsigned samples.
- Time-shares a single instance of the team's 4-bit `comparator` block. Each sample is compared against the running minimum, then against the running maximum, in two consecutive cycles.
- Sits between a sample source using a valid/ready handshake and downstream display/result logic.
- One run covers N_SAMPLES samples and ends with a one-cycle done pulse.

Parameters:
- N_SAMPLES, 8, samples per run; legal range 2..15.
- CNT_W, 4, width of the internal sample counter; must hold N_SAMPLES.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begins a run; sampled only in IDLE.
- abort  input  1  cancels a run; returns to IDLE next edge; no done pulse.
- in_valid  input  1  source has a sample on in_data.
- in_data  input  4  unsigned sample.
- in_ready  output  1  block accepts a sample this cycle.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a run completes.
- min_out  output  4  running/final minimum.
- max_out  output  4  running/final maximum.

Behaviour:
- Reset (async, rst=1): state=IDLE; in_ready=0, busy=0, done=0, min_out=4'h0, max_out=4'h0; counter=0; sample register=0.
- States: IDLE, WAIT_IN, CMP_MIN, CMP_MAX, DONE.
- IDLE:
  - start=1: clear counter, go to WAIT_IN.
  - min_out/max_out keep the previous run's results.
- WAIT_IN:
  - in_ready=1 only in this state; a transfer occurs when in_valid & in_ready.
  - First sample (counter=0): min_out<=in_data, max_out<=in_data, counter<=1; stay in WAIT_IN.
  - Later samples: sample register<=in_data; go to CMP_MIN.
  - No transfer: hold.
- CMP_MIN:
  - Comparator X=sample register, Y=min_out.
  - If lt=1: min_out<=sample register.
  - Go to CMP_MAX.
- CMP_MAX:
  - Comparator X=sample register, Y=max_out.
  - If gt=1: max_out<=sample register.
  - counter<=counter+1.
  - If counter+1==N_SAMPLES: go to DONE; otherwise go to WAIT_IN.
- DONE: done=1 for exactly this cycle; go to IDLE.
- Equal values (eq=1): no update. Ties keep the earliest occurrence.
- Comparator operands are driven only from registered state. The comparator output is used combinationally within the same cycle; no extra pipeline stage.
- Throughput: first sample takes 1 cycle; each later sample takes 3 cycles (accept + 2 compares).
- Latency with in_valid held high: done is high in the cycle following edge 3*N_SAMPLES-2, counting the start-sampling edge as edge 0.
- start while busy: ignored.
- abort:
  - Has priority over all transitions in WAIT_IN, CMP_MIN and CMP_MAX: next state is IDLE.
  - min_out/max_out keep their partial values; counter clears.
  - abort in DONE or IDLE: no effect; done still pulses.
- start and abort both high in IDLE: abort wins; stay in IDLE.
- in_valid while not in WAIT_IN: ignored (in_ready=0); the source must hold data.
- rst mid-run: immediate return to reset values.

Optional Feature:
- Macro: MINMAX_IDX_EN.
- When defined:
  - Adds outputs min_idx and max_idx, each CNT_W wide, reset to 0.
  - Each holds the 0-based sample index at which the current min_out/max_out was captured.
  - The first sample sets both to 0. Updates occur in the same cycle as the corresponding min_out/max_out update.
  - On a tie, the index of the first occurrence is kept.
- When undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset: rst pulsed mid-CMP_MAX with min_out=3 -> all outputs 0 and state IDLE immediately, without waiting for a clock edge.
- N_SAMPLES=4, in_valid held high, samples 5,2,9,2:
  - min_out=2, max_out=9, single done pulse in the cycle after edge 10.
  - With MINMAX_IDX_EN: min_idx=1, max_idx=2.
- N_SAMPLES=4, samples 7,7,7,7 -> min_out=7, max_out=7; with MINMAX_IDX_EN both indices 0.
- Boundary values, N_SAMPLES=4, samples 0,15,0,15 -> min_out=0, max_out=15; indices 0 and 1.
- Backpressure: in_valid toggled 1-0-0-1 between samples -> results identical to the continuous case; in_ready high only in WAIT_IN; no sample accepted twice.
- Abort after 2 of 4 samples (8,3) -> IDLE next edge, no done, min_out=3, max_out=8; a following start runs cleanly from counter 0.
